// File: rtl/lamp_state_decoder_pkg.sv
// Shared widths, FSM encoding and result payload for the lamp feedback decoder.
package lamp_state_decoder_pkg;

  localparam int unsigned N_LIGHTS = 15;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned BUS_W    = N_LIGHTS + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] active_lights;
    logic             thermo_ok;
  } result_t;

endpackage

// File: rtl/lamp_bit_scanner.sv
// Serial scanner: walks the captured lamp bits one per step, counting ones and
// flagging any one that follows a zero (a bubble) or a set top bit.
module lamp_bit_scanner
  import lamp_state_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [BUS_W-1:0] lights_state,
  output logic             last_c,
  output logic [CNT_W-1:0] cnt_c,
  output logic             err_c
);

  logic [N_LIGHTS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                seen0_q, seen0_d;
  logic                err_q, err_d;
  logic                bit_c;

  // cnt_c/err_c are the totals including the bit under test this cycle
  always_comb begin
    bit_c  = shreg_q[idx_q];
    last_c = (idx_q == CNT_W'(N_LIGHTS - 1));
    cnt_c  = CNT_W'(cnt_q + CNT_W'(bit_c));
    err_c  = err_q | (bit_c & seen0_q);
  end

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seen0_d = seen0_q;
    err_d   = err_q;
    if (load) begin
      shreg_d = lights_state[N_LIGHTS-1:0];
      idx_d   = '0;
      cnt_d   = '0;
      seen0_d = 1'b0;
      err_d   = lights_state[N_LIGHTS];
    end else if (step) begin
      cnt_d   = cnt_c;
      err_d   = err_c;
      seen0_d = seen0_q | ~bit_c;
      idx_d   = CNT_W'(idx_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      seen0_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seen0_q <= seen0_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/lamp_state_decoder.sv
// Lamp thermometer decoder: start/done handshake around a serial bit scanner,
// with results held in output registers between decodes.
module lamp_state_decoder
  import lamp_state_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BUS_W-1:0] lights_state,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] active_lights,
  output logic             thermo_ok
);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  result_t          res_q, res_d;
  logic             load_c;
  logic             step_c;
  logic             last_c;
  logic [CNT_W-1:0] cnt_c;
  logic             err_c;

  lamp_bit_scanner u_scanner (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_c),
    .step         (step_c),
    .lights_state (lights_state),
    .last_c       (last_c),
    .cnt_c        (cnt_c),
    .err_c        (err_c)
  );

  // Results latch on the SCAN->DONE edge so they appear together with done
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    res_d   = res_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        step_c = 1'b1;
        if (last_c) begin
          state_d             = ST_DONE;
          done_d              = 1'b1;
          res_d.active_lights = cnt_c;
          res_d.thermo_ok     = ~err_c;
        end
      end
      ST_DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign active_lights = res_q.active_lights;
  assign thermo_ok     = res_q.thermo_ok;

endmodule

// File: tb/tb_lamp_state_decoder.sv
// Scoreboard bench for lamp_state_decoder: randomized and directed codes against
// a popcount/thermometer reference, checked by an independent done monitor.
module tb_lamp_state_decoder;

  localparam int NL = 15;

  typedef struct {
    int al;
    int ok;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] lights_state;
  logic        busy;
  logic        done;
  logic [3:0]  active_lights;
  logic        thermo_ok;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   held_al  = 0;
  int   held_ok  = 0;

  lamp_state_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .lights_state  (lights_state),
    .busy          (busy),
    .done          (done),
    .active_lights (active_lights),
    .thermo_ok     (thermo_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count = number of lit lamps; legal only if they form a solid run from bit 0
  function automatic exp_t model(input logic [15:0] v);
    exp_t r;
    int   pop = 0;
    for (int i = 0; i < NL; i++) if (v[i]) pop++;
    r.al = pop;
    r.ok = (v[15] == 1'b0 && int'(v[14:0]) == (1 << pop) - 1) ? 1 : 0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      held_al = 0;
      held_ok = 0;
    end else if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("active_lights", int'(active_lights), e.al);
        check("thermo_ok", int'(thermo_ok), e.ok);
        held_al = int'(active_lights);
        held_ok = int'(thermo_ok);
      end
    end else begin
      check("hold_active_lights", int'(active_lights), held_al);
      check("hold_thermo_ok", int'(thermo_ok), held_ok);
    end
  end

  task automatic decode(input logic [15:0] v);
    int edges;
    int busy_n;
    bit seen;
    @(negedge clk);
    lights_state = v;
    start        = 1'b1;
    sb_q.push_back(model(v));
    @(posedge clk);
    #1;
    start  = 1'b0;
    busy_n = busy ? 1 : 0;
    edges  = 0;
    seen   = 1'b0;
    while (!seen && edges < 40) begin
      lights_state = 16'($urandom);
      start        = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      edges++;
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    start = 1'b0;
    check("done_latency", edges, NL);
    check("busy_cycles", busy_n, NL);
  endtask

  initial begin
    logic [15:0] pat [2];
    logic [15:0] v;
    rst_n        = 1'b0;
    start        = 1'b0;
    lights_state = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_active_lights", int'(active_lights), 0);
    check("reset_thermo_ok", int'(thermo_ok), 0);

    decode(16'h007F);
    for (int k = 0; k <= NL; k++) begin
      v = 16'((1 << k) - 1);
      decode(v);
    end
    decode(16'h0005);
    decode(16'h8000);
    decode(16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) v = 16'((1 << $urandom_range(0, NL)) - 1);
      else v = 16'($urandom);
      decode(v);
    end

    // start held high: back-to-back decodes with the bus scrambled mid-scan
    pat[0] = 16'h0003;
    pat[1] = 16'h01FF;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      lights_state = pat[s % 2];
      start        = 1'b1;
      sb_q.push_back(model(pat[s % 2]));
      @(posedge clk);
      repeat (NL) begin
        @(negedge clk);
        lights_state = 16'($urandom);
        @(posedge clk);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("b2b_sb_drained", sb_q.size(), 0);

    // reset in the middle of a scan: outputs clear at once and no done follows
    @(negedge clk);
    lights_state = 16'h3FFF;
    start        = 1'b1;
    sb_q.push_back(model(16'h3FFF));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_active_lights", int'(active_lights), 0);
    check("midreset_thermo_ok", int'(thermo_ok), 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    decode(16'h3FFF);

    repeat (3) @(posedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
